// File: rtl/aes_pkg.sv
// Shared AES types, state encoding and byte-level transforms used by the stream engine.
// S-boxes are computed as GF(2^8) inverse plus affine map rather than a lookup table.
package aes_pkg;

  typedef enum logic [1:0] {
    KLEN_128 = 2'b00,
    KLEN_192 = 2'b01,
    KLEN_256 = 2'b10,
    KLEN_BAD = 2'b11
  } klen_t;

  typedef logic [1:0] state_t;
  localparam state_t IDLE   = 2'd0;
  localparam state_t EXPAND = 2'd1;
  localparam state_t ROUND  = 2'd2;

  // The illegal encoding falls through to 256 when it is not rejected upstream.
  function automatic logic [3:0] nk_of(input klen_t k);
    case (k)
      KLEN_128: return 4'd4;
      KLEN_192: return 4'd6;
      default:  return 4'd8;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input klen_t k);
    case (k)
      KLEN_128: return 4'd10;
      KLEN_192: return 4'd12;
      default:  return 4'd14;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // a^254 == a^-1 in GF(2^8); maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h01;
    p   = a;
    for (int k = 1; k < 8; k++) begin
      p   = gf_mul(p, p);
      acc = gf_mul(acc, p);
    end
    return acc;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b};
    return d[15-n -: 8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] x;
    x = gf_inv(b);
    return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return gf_inv(rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05);
  endfunction

  // Bit position of the MSB of state byte S[r][c]; the block is column-major, S0,0 on top.
  function automatic int state_pos(input int r, input int c);
    return 127 - 8 * (4 * c + r);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = sbox(s[127-8*k -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = inv_sbox(s[127-8*k -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) o[state_pos(r, c) -: 8] = s[state_pos(r, (c + r) % 4) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) o[state_pos(r, (c + r) % 4) -: 8] = s[state_pos(r, c) -: 8];
    return o;
  endfunction

  function automatic logic [31:0] mixcol(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [31:0] invmixcol(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) o[127-32*c -: 32] = mixcol(s[127-32*c -: 32]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) o[127-32*c -: 32] = invmixcol(s[127-32*c -: 32]);
    return o;
  endfunction

endpackage

// File: rtl/aes_stream_engine_if.sv
// Key, block and result channels of the AES stream engine, with the engine on the slave side.
interface aes_stream_engine_if #(
    parameter int unsigned KMAX = 256
);
  logic            key_valid;
  logic            key_ready;
  logic [1:0]      klen;
  logic [KMAX-1:0] key;
  logic            in_valid;
  logic            in_ready;
  logic            dir;
  logic [127:0]    in_data;
  logic            out_valid;
  logic            out_ready;
  logic [127:0]    out_data;
  logic            key_loaded;
  logic            err;

  modport slave(
      input key_valid, klen, key, in_valid, dir, in_data, out_ready,
      output key_ready, in_ready, out_valid, out_data, key_loaded, err
  );

  modport master(
      output key_valid, klen, key, in_valid, dir, in_data, out_ready,
      input key_ready, in_ready, out_valid, out_data, key_loaded, err
  );
endinterface

// File: rtl/aes_key_sched.sv
// Word-serial AES key expander with a schedule RAM read one round key at a time.
// Loads Nk words on load, then produces one word per cycle while run is high.
module aes_key_sched
  import aes_pkg::*;
#(
    parameter int unsigned KMAX = 256,
    parameter int unsigned CW   = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            run,
    input  logic [1:0]      klen,
    input  logic [KMAX-1:0] key,
    input  logic [CW-1:0]   rd_idx,
    output logic [127:0]    rk,
    output logic [CW-1:0]   nr,
    output logic            last
);
  localparam int unsigned KW    = KMAX / 32;
  localparam int unsigned WORDS = 4 * (KW + 7);

  logic [31:0]   w [WORDS];
  logic [CW-1:0] i_q, j_q, nk_q, nr_q;
  logic [7:0]    rcon_q;
  logic [31:0]   prev, temp, nxt;
  logic [CW-1:0] base;

  always_comb begin
    prev = w[i_q - CW'(1)];
    temp = prev;
    if (j_q == '0) begin
      temp = sub_word({prev[23:0], prev[31:24]}) ^ {rcon_q, 24'h0};
    end else if (nk_q == CW'(8) && j_q == CW'(4)) begin
      temp = sub_word(prev);
    end
    nxt = w[i_q - nk_q] ^ temp;
  end

  assign last = run && (i_q == ((nr_q << 2) | CW'(3)));
  assign nr   = nr_q;
  assign base = rd_idx << 2;
  assign rk   = {w[base], w[base + CW'(1)], w[base + CW'(2)], w[base + CW'(3)]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_q    <= '0;
      j_q    <= '0;
      nk_q   <= '0;
      nr_q   <= '0;
      rcon_q <= 8'h00;
    end else if (load) begin
      nk_q   <= CW'(nk_of(klen_t'(klen)));
      nr_q   <= CW'(nr_of(klen_t'(klen)));
      i_q    <= CW'(nk_of(klen_t'(klen)));
      j_q    <= '0;
      rcon_q <= 8'h01;
    end else if (run) begin
      i_q <= i_q + CW'(1);
      j_q <= (j_q == nk_q - CW'(1)) ? '0 : j_q + CW'(1);
      if (j_q == '0) rcon_q <= xtime(rcon_q);
    end
  end

  // Unused upper key words are harmless: expansion overwrites them for short keys.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int k = 0; k < KW; k++) w[k] <= key[KMAX-1-32*k -: 32];
    end else if (run) begin
      w[i_q] <= nxt;
    end
  end
endmodule

// File: rtl/aes_stream_engine.sv
// Iterative AES-128/192/256 encrypt/decrypt engine with a cached key schedule.
// Build option AES_KLEN_CHECK_EN rejects klen=11 and raises a sticky err flag.
module aes_stream_engine
  import aes_pkg::*;
#(
    parameter int unsigned KMAX = 256,
    parameter int unsigned CW   = 6
) (
    input logic                clk,
    input logic                reset,
    aes_stream_engine_if.slave bus
);
  state_t        state_q;
  logic          key_loaded_q, out_valid_q, err_q, dir_q;
  logic [127:0]  st_q, out_q, rk, rnd, t;
  logic [CW-1:0] r_q, nr, rd_idx;
  logic          key_bad, key_fire, ks_load, ks_run, ks_last, blk_fire, last_rnd;

`ifdef AES_KLEN_CHECK_EN
  assign key_bad = (bus.klen == 2'b11);
`else
  assign key_bad = 1'b0;
`endif

  assign key_fire = (state_q == IDLE) && bus.key_valid;
  assign ks_load  = key_fire && !key_bad;
  assign ks_run   = (state_q == EXPAND);
  assign last_rnd = (r_q == nr);

  // A pending key always wins over a pending block.
  assign bus.key_ready  = (state_q == IDLE);
  assign bus.in_ready   = (state_q == IDLE) && key_loaded_q && (!out_valid_q || bus.out_ready) &&
                          !bus.key_valid;
  assign blk_fire       = bus.in_valid && bus.in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_q;
  assign bus.key_loaded = key_loaded_q;
  assign bus.err        = err_q;

  aes_key_sched #(
      .KMAX(KMAX),
      .CW  (CW)
  ) u_key_sched (
      .clk   (clk),
      .reset (reset),
      .load  (ks_load),
      .run   (ks_run),
      .klen  (bus.klen),
      .key   (bus.key),
      .rd_idx(rd_idx),
      .rk    (rk),
      .nr    (nr),
      .last  (ks_last)
  );

  always_comb begin
    if (state_q == ROUND) rd_idx = dir_q ? nr - r_q : r_q;
    else                  rd_idx = bus.dir ? nr : '0;
  end

  always_comb begin
    t   = '0;
    rnd = '0;
    if (!dir_q) begin
      t   = shift_rows(sub_bytes(st_q));
      rnd = (last_rnd ? t : mix_columns(t)) ^ rk;
    end else begin
      t   = inv_sub_bytes(inv_shift_rows(st_q)) ^ rk;
      rnd = last_rnd ? t : inv_mix_columns(t);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      key_loaded_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_q        <= '0;
      err_q        <= 1'b0;
      st_q         <= '0;
      dir_q        <= 1'b0;
      r_q          <= '0;
    end else begin
      if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (key_fire) begin
            if (key_bad) begin
              err_q <= 1'b1;
            end else begin
              err_q        <= 1'b0;
              key_loaded_q <= 1'b0;
              state_q      <= EXPAND;
            end
          end else if (blk_fire) begin
            st_q    <= bus.in_data ^ rk;
            dir_q   <= bus.dir;
            r_q     <= CW'(1);
            state_q <= ROUND;
          end
        end
        EXPAND: begin
          if (ks_last) begin
            key_loaded_q <= 1'b1;
            state_q      <= IDLE;
          end
        end
        ROUND: begin
          st_q <= rnd;
          r_q  <= r_q + CW'(1);
          if (last_rnd) begin
            out_q       <= rnd;
            out_valid_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_stream_engine.sv
// Directed-vector bench for aes_stream_engine using FIPS-197 known-answer vectors.
module tb_aes_stream_engine;
  localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K256 =
      256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  aes_stream_engine_if #(.KMAX(256)) bus ();

  aes_stream_engine #(
      .KMAX(256),
      .CW  (6)
  ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // {key_ready, in_ready, out_valid, key_loaded, err}
  function automatic logic [127:0] flags();
    return 128'({bus.key_ready, bus.in_ready, bus.out_valid, bus.key_loaded, bus.err});
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_flags"}, flags(), 128'h10);
    check({tag, "_data"}, bus.out_data, 128'h0);
  endtask

  // cyc = cycles spent with key_ready low after the accept edge.
  task automatic send_key(input logic [1:0] kl, input logic [255:0] k, output int cyc);
    @(negedge clk);
    bus.klen = kl;
    bus.key = k;
    bus.key_valid = 1'b1;
    @(posedge clk);
    #1 bus.key_valid = 1'b0;
    cyc = 0;
    @(negedge clk);
    while (!bus.key_ready && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  // lat = clock edges from the accept edge through the edge that raises out_valid.
  task automatic send_blk(input logic d, input logic [127:0] data, output int lat);
    int n;
    @(negedge clk);
    bus.dir = d;
    bus.in_data = data;
    bus.in_valid = 1'b1;
    #1;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!bus.out_valid && lat < 60) begin
      lat++;
      @(negedge clk);
    end
  endtask

  // Called at a negedge with out_valid high; consumes the result on the next edge.
  task automatic take(input string tag, input logic [127:0] exp);
    check(tag, bus.out_data, exp);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  initial begin
    int   cyc;
    int   lat;
    int   n;
    logic ok;

    bus.key_valid = 1'b0;
    bus.klen      = 2'b00;
    bus.key       = '0;
    bus.in_valid  = 1'b0;
    bus.dir       = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    #1 reset = 1'b1;
    #1 check_reset("por");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // AES-128
    send_key(2'b00, K128, cyc);
    check("exp128_cyc", 128'(cyc), 128'(40));
    check("exp128_loaded", 128'(bus.key_loaded), 128'(1));
    send_blk(1'b0, PT, lat);
    check("enc128_lat", 128'(lat), 128'(11));
    take("enc128", C128);

    // AES-192
    send_key(2'b01, K192, cyc);
    check("exp192_cyc", 128'(cyc), 128'(46));
    send_blk(1'b0, PT, lat);
    check("enc192_lat", 128'(lat), 128'(13));
    take("enc192", C192);

    // AES-256 encrypt then decrypt under the cached schedule
    send_key(2'b10, K256, cyc);
    check("exp256_cyc", 128'(cyc), 128'(52));
    send_blk(1'b0, PT, lat);
    check("enc256_lat", 128'(lat), 128'(15));
    take("enc256", C256);
    check("dec256_loaded", 128'(bus.key_loaded), 128'(1));
    send_blk(1'b1, C256, lat);
    check("dec256_lat", 128'(lat), 128'(15));
    take("dec256", PT);

    // Backpressure: hold the result for 20 cycles while a new block waits
    send_blk(1'b0, PT, lat);
    ok = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.dir = 1'b1;
      bus.in_data = C256;
      #1;
      if (bus.out_data !== C256 || bus.in_ready || !bus.out_valid) ok = 1'b0;
    end
    check("bp_hold", 128'(ok), 128'(1));
    @(negedge clk);
    bus.out_ready = 1'b1;
    #1 check("bp_in_ready", 128'(bus.in_ready), 128'(1));
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    bus.in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    check("bp_clear", 128'(bus.out_valid), 128'(0));
    while (!bus.out_valid && lat < 60) begin
      lat++;
      @(negedge clk);
    end
    check("bp_lat", 128'(lat), 128'(15));
    take("bp_dec", PT);

    // Key and block offered together: key wins, block waits for the new schedule
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.klen = 2'b00;
    bus.key = K128;
    bus.in_valid = 1'b1;
    bus.dir = 1'b0;
    bus.in_data = PT;
    #1;
    check("kb_in_ready", 128'(bus.in_ready), 128'(0));
    check("kb_key_ready", 128'(bus.key_ready), 128'(1));
    @(posedge clk);
    #1 bus.key_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("kb_wait", 128'(n), 128'(40));
    check("kb_loaded", 128'(bus.key_loaded), 128'(1));
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    bus.key_valid = 1'b1;  // offered mid-ROUND
    #1;
    ok = 1'b1;
    while (!bus.out_valid && lat < 60) begin
      if (bus.key_ready) ok = 1'b0;
      lat++;
      @(negedge clk);
    end
    check("kr_blocked", 128'(ok), 128'(1));
    check("kr_lat", 128'(lat), 128'(11));
    check("kr_key_ready", 128'(bus.key_ready), 128'(1));
    check("kr_enc", bus.out_data, C128);
    @(posedge clk);
    #1 bus.key_valid = 1'b0;
    ok = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.key_ready && n < 200) begin
      if (bus.out_data !== C128 || !bus.out_valid) ok = 1'b0;
      n++;
      @(negedge clk);
    end
    check("kr_exp_cyc", 128'(n), 128'(40));
    check("kr_out_stable", 128'(ok), 128'(1));
    take("kr_out", C128);

    // Reset mid-ROUND (out_data is nonzero beforehand)
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.dir = 1'b0;
    bus.in_data = PT;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1 check_reset("rst_round");
    @(negedge clk);
    reset = 1'b0;

    // Reset mid-EXPAND
    @(negedge clk);
    bus.klen = 2'b10;
    bus.key = K256;
    bus.key_valid = 1'b1;
    @(posedge clk);
    #1 bus.key_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1 check_reset("rst_expand");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 128'(bus.in_ready), 128'(0));

    // Illegal key length
    send_key(2'b00, K128, cyc);
    check("re128_cyc", 128'(cyc), 128'(40));
`ifdef AES_KLEN_CHECK_EN
    @(negedge clk);
    bus.klen = 2'b11;
    bus.key = K256;
    bus.key_valid = 1'b1;
    @(posedge clk);
    #1 bus.key_valid = 1'b0;
    @(negedge clk);
    check("bad_err", 128'(bus.err), 128'(1));
    check("bad_loaded", 128'(bus.key_loaded), 128'(1));
    check("bad_key_ready", 128'(bus.key_ready), 128'(1));
    send_blk(1'b0, PT, lat);
    check("bad_keep_lat", 128'(lat), 128'(11));
    take("bad_keep_enc", C128);
    check("bad_err_sticky", 128'(bus.err), 128'(1));
    send_key(2'b00, K128, cyc);
    check("bad_clear_cyc", 128'(cyc), 128'(40));
    check("bad_err_clear", 128'(bus.err), 128'(0));
`else
    send_key(2'b11, K256, cyc);
    check("k11_cyc", 128'(cyc), 128'(52));
    check("k11_err", 128'(bus.err), 128'(0));
    send_blk(1'b0, PT, lat);
    check("k11_lat", 128'(lat), 128'(15));
    take("k11_enc", C256);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
